// File: rtl/seg_serial_rx_pkg.sv
// rtl/seg_serial_rx_pkg.sv - shared state encoding, defaults and seven-segment table
package seg_serial_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_CLOSE = 2'd2
   } rx_state_t;

   localparam int DEF_FRAME_BITS = 64;
   localparam int DEF_IDLE_CYC   = 64;

   // Entry i is the active-low pattern for hex digit i, dp bit forced high
   localparam logic [127:0] SEG_TABLE = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

   function automatic logic [7:0] seg_entry(input int idx);
      return SEG_TABLE[idx*8 +: 8];
   endfunction

endpackage

// File: rtl/seg_serial_rx_decode.sv
// rtl/seg_serial_rx_decode.sv - one segment byte to hex nibble with unknown-pattern flag
module seg7_decode
   import seg_serial_rx_pkg::*;
(
   input  logic [7:0] seg,
   output logic [3:0] nibble,
   output logic       err
);

   logic [7:0] key;

   assign key = seg | 8'h80;

   always_comb begin
      nibble = 4'h0;
      err    = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (key == seg_entry(i)) begin
            nibble = 4'(i);
            err    = 1'b0;
         end
      end
   end

endmodule

// File: rtl/seg_serial_rx.sv
// rtl/seg_serial_rx.sv - captures a serial seven-segment display stream into decoded frames
module seg_serial_rx
   import seg_serial_rx_pkg::*;
#(
   parameter int IDLE_CYC   = DEF_IDLE_CYC,
   parameter int FRAME_BITS = DEF_FRAME_BITS
) (
   input  logic        clk1,
   input  logic        rst,
   input  logic        SEG_CLK,
   input  logic        SEG_DT,
   output logic [63:0] frame,
   output logic        frame_valid,
   output logic        frame_err,
   output logic [31:0] digits,
   output logic [7:0]  dp,
   output logic [7:0]  digit_err,
   output logic        busy
);

   localparam int CW = $clog2(FRAME_BITS + 2);
   localparam int IW = $clog2(IDLE_CYC + 1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(FRAME_BITS);
   localparam logic [CW-1:0] CNT_SAT   = CW'(FRAME_BITS + 1);
   localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYC - 1);

   rx_state_t     state, next_state;
   logic [2:0]    clk_sync;
   logic [1:0]    dt_sync;
   logic          edge_det;
   logic          bit_in;
   logic [63:0]   shreg;
   logic [CW-1:0] bit_cnt;
   logic [IW-1:0] idle_cnt;
   logic [31:0]   dec_nib;
   logic [7:0]    dec_err;
   logic [7:0]    dec_dp;

   // Third SEG_CLK flop only remembers the previous synchronized level for edge detect
   assign edge_det = clk_sync[1] & ~clk_sync[2];
   assign bit_in   = dt_sync[1];
   assign busy     = (state == ST_SHIFT);

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         clk_sync <= 3'b000;
         dt_sync  <= 2'b00;
      end else begin
         clk_sync <= {clk_sync[1:0], SEG_CLK};
         dt_sync  <= {dt_sync[0], SEG_DT};
      end
   end

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:  if (edge_det) next_state = ST_SHIFT;
         ST_SHIFT: if (!edge_det && idle_cnt == IDLE_LAST) next_state = ST_CLOSE;
         ST_CLOSE: next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   genvar g;
   generate
      for (g = 0; g < 8; g++) begin : g_dec
         seg7_decode u_dec (
            .seg    (shreg[g*8 +: 8]),
            .nibble (dec_nib[g*4 +: 4]),
            .err    (dec_err[g])
         );
         assign dec_dp[g] = ~shreg[g*8 + 7];
      end
   endgenerate

   // Edges arriving during CLOSE fall through every branch and are dropped
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         shreg       <= '0;
         bit_cnt     <= '0;
         idle_cnt    <= '0;
         frame       <= '1;
         digits      <= '0;
         dp          <= '0;
         digit_err   <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (edge_det) begin
                  shreg    <= {shreg[62:0], bit_in};
                  bit_cnt  <= CW'(1);
                  idle_cnt <= '0;
               end
            end
            ST_SHIFT: begin
               if (edge_det) begin
                  shreg    <= {shreg[62:0], bit_in};
                  idle_cnt <= '0;
                  if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CW'(1);
               end else if (idle_cnt != IDLE_LAST) begin
                  idle_cnt <= idle_cnt + IW'(1);
               end
            end
            ST_CLOSE: begin
               if (bit_cnt == CNT_FULL) begin
                  frame       <= shreg;
                  digits      <= dec_nib;
                  dp          <= dec_dp;
                  digit_err   <= dec_err;
                  frame_valid <= 1'b1;
               end else begin
                  frame_err   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seg_serial_rx.sv
// tb/tb_seg_serial_rx.sv - self-checking bench for seg_serial_rx
module tb_seg_serial_rx;

   localparam int IDLE_CYC = 64;

   logic        clk1 = 1'b0;
   logic        rst;
   logic        SEG_CLK;
   logic        SEG_DT;
   logic [63:0] frame;
   logic        frame_valid;
   logic        frame_err;
   logic [31:0] digits;
   logic [7:0]  dp;
   logic [7:0]  digit_err;
   logic        busy;

   seg_serial_rx #(.IDLE_CYC(IDLE_CYC), .FRAME_BITS(64)) dut (
      .clk1        (clk1),
      .rst         (rst),
      .SEG_CLK     (SEG_CLK),
      .SEG_DT      (SEG_DT),
      .frame       (frame),
      .frame_valid (frame_valid),
      .frame_err   (frame_err),
      .digits      (digits),
      .dp          (dp),
      .digit_err   (digit_err),
      .busy        (busy)
   );

   always #5 clk1 = ~clk1;

   typedef struct {
      logic        is_valid;
      logic [63:0] frame;
      logic        has_lit;
      logic [31:0] lit_digits;
      logic [7:0]  lit_dp;
      logic [7:0]  lit_derr;
   } ev_t;

   ev_t ev_q [16];
   int  wr = 0;
   int  rd = 0;
   logic done = 1'b0;
   logic expect_busy = 1'b0;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [63:0] m_frame;
   logic [31:0] m_digits;
   logic [7:0]  m_dp;
   logic [7:0]  m_derr;
   ev_t         ev;

   function automatic void model_decode(input logic [63:0] f, output logic [31:0] d,
                                        output logic [7:0] p, output logic [7:0] e);
      logic [7:0] b;
      logic [3:0] n;
      d = '0;
      for (int k = 0; k < 8; k++) begin
         b = f[k*8 +: 8];
         p[k] = ~b[7];
         e[k] = 1'b0;
         case (b | 8'h80)
            8'hC0: n = 4'h0;  8'hF9: n = 4'h1;  8'hA4: n = 4'h2;  8'hB0: n = 4'h3;
            8'h99: n = 4'h4;  8'h92: n = 4'h5;  8'h82: n = 4'h6;  8'hF8: n = 4'h7;
            8'h80: n = 4'h8;  8'h90: n = 4'h9;  8'h88: n = 4'hA;  8'h83: n = 4'hB;
            8'hC6: n = 4'hC;  8'hA1: n = 4'hD;  8'h86: n = 4'hE;  8'h8E: n = 4'hF;
            default: begin n = 4'h0; e[k] = 1'b1; end
         endcase
         d[k*4 +: 4] = n;
      end
   endfunction

   always @(negedge clk1) begin
      cyc++;
      if (rst) begin
         m_frame  = '1;
         m_digits = '0;
         m_dp     = '0;
         m_derr   = '0;
         checks++;
         if (busy !== 1'b0 || frame_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy/valid/err=%b%b%b required 000", busy, frame_valid, frame_err);
         end
      end else if (frame_valid || frame_err) begin
         checks++;
         if (frame_valid && frame_err) begin
            errors++;
            $display("FAIL pulse_exclusive: frame_valid=1 frame_err=1 required not both");
         end else if (rd == wr) begin
            errors++;
            $display("FAIL unexpected_pulse: valid=%b err=%b required no pulse", frame_valid, frame_err);
         end else begin
            ev = ev_q[rd % 16];
            rd++;
            checks++;
            if (frame_valid !== ev.is_valid) begin
               errors++;
               $display("FAIL pulse_kind: frame_valid=%b required %b", frame_valid, ev.is_valid);
            end else if (ev.is_valid) begin
               m_frame = ev.frame;
               model_decode(ev.frame, m_digits, m_dp, m_derr);
               if (ev.has_lit) begin
                  checks++;
                  if (digits !== ev.lit_digits || dp !== ev.lit_dp || digit_err !== ev.lit_derr) begin
                     errors++;
                     $display("FAIL literal_decode: digits=%h dp=%h derr=%h required %h %h %h",
                              digits, dp, digit_err, ev.lit_digits, ev.lit_dp, ev.lit_derr);
                  end
               end
            end
         end
      end
      checks++;
      if ({frame, digits, dp, digit_err} !== {m_frame, m_digits, m_dp, m_derr}) begin
         errors++;
         $display("FAIL outputs: frame=%h digits=%h dp=%h derr=%h required %h %h %h %h",
                  frame, digits, dp, digit_err, m_frame, m_digits, m_dp, m_derr);
      end
      if (expect_busy) begin
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_mid_frame: busy=%b required 1", busy);
         end
      end
      if (done || cyc > 80000) begin
         checks++;
         if (!done) begin
            errors++;
            $display("FAIL timeout: stimulus not done after %0d cycles", cyc);
         end else if (rd != wr) begin
            errors++;
            $display("FAIL pulses_seen: got %0d pulses required %0d", rd, wr);
         end
         $display("Result: errors=%0d of %0d checks", errors, checks);
         $finish;
      end
   end

   task automatic send_bit(input logic b);
      SEG_DT = b;
      #100 SEG_CLK = 1'b1;
      #100 SEG_CLK = 1'b0;
   endtask

   task automatic send_frame(input logic [127:0] bits, input int n, input logic push,
                             input logic lit, input logic [31:0] ld, input logic [7:0] lp,
                             input logic [7:0] le);
      if (push) begin
         ev_q[wr % 16].is_valid   = (n == 64);
         ev_q[wr % 16].frame      = bits[63:0];
         ev_q[wr % 16].has_lit    = lit;
         ev_q[wr % 16].lit_digits = ld;
         ev_q[wr % 16].lit_dp     = lp;
         ev_q[wr % 16].lit_derr   = le;
         wr++;
      end
      for (int i = n - 1; i >= 0; i--) begin
         send_bit(bits[i]);
         if (i == n - 10) expect_busy = 1'b1;
         if (i == n - 11) expect_busy = 1'b0;
      end
   endtask

   task automatic wait_close();
      repeat (IDLE_CYC + 5) @(posedge clk1);
      for (int k = 0; k < 300 && rd != wr; k++) @(posedge clk1);
      #2;
   endtask

   localparam logic [63:0] F_CLOCK = 64'hC0C0_A4B0_9290_9280;
   localparam logic [63:0] F_BAD0  = 64'hC0C0_A4B0_9290_927F;
   localparam logic [63:0] F_DP    = 64'hF9F9_F9F9_F9F9_F940;
   localparam logic [63:0] F_HEX   = 64'h8883_C6A1_868E_F990;

   initial begin
      rst     = 1'b1;
      SEG_CLK = 1'b0;
      SEG_DT  = 1'b0;
      #23 rst = 1'b0;
      repeat (5) @(posedge clk1);
      #2;
      send_frame({64'd0, F_CLOCK}, 64, 1'b1, 1'b1, 32'h0023_5958, 8'h00, 8'h00);
      wait_close();
      send_frame({64'd0, F_BAD0}, 63, 1'b1, 1'b0, 32'h0, 8'h0, 8'h0);
      wait_close();
      send_frame({62'd0, 2'b10, F_DP}, 66, 1'b1, 1'b0, 32'h0, 8'h0, 8'h0);
      wait_close();
      send_frame({64'd0, F_BAD0}, 64, 1'b1, 1'b1, 32'h0023_5950, 8'h01, 8'h01);
      wait_close();
      send_frame({64'd0, F_DP}, 64, 1'b1, 1'b1, 32'h1111_1110, 8'h01, 8'h00);
      wait_close();
      send_frame({64'd0, F_HEX}, 30, 1'b0, 1'b0, 32'h0, 8'h0, 8'h0);
      #1 rst = 1'b1;
      #30 rst = 1'b0;
      repeat (3) @(posedge clk1);
      #2;
      send_frame({64'd0, F_CLOCK}, 64, 1'b1, 1'b1, 32'h0023_5958, 8'h00, 8'h00);
      wait_close();
      send_frame({64'd0, F_HEX}, 64, 1'b1, 1'b1, 32'hABCD_EF19, 8'h00, 8'h00);
      repeat (IDLE_CYC + 5) @(posedge clk1);
      #2;
      send_frame({64'd0, F_CLOCK}, 64, 1'b1, 1'b1, 32'h0023_5958, 8'h00, 8'h00);
      wait_close();
      done = 1'b1;
   end

endmodule
